clk_prescaler: RTL and testbench
================================

// Module: clk_prescaler
//
// PURPOSE
//   Derives the slow timing signals CLK_1MHz and CLK_1Hz from the 50 MHz system clock, plus
//   matching single-cycle tick strobes.
//   Sits directly upstream of the I/O stages that sample CLK_1MHz / CLK_1Hz and edge-detect them
//   on CLK.
//   All outputs are registered in the CLK domain.
//   Slow "clocks" are data signals, never used as clocks.
//
// PARAMETERS
//   CLK_FREQ_HZ  50_000_000  frequency of CLK
//   F1_HZ        1_000_000   frequency of CLK_1MHz / TICK_1MHz
//   F2_HZ        1           frequency of CLK_1Hz / TICK_1Hz
//   Derived: DIV1 = CLK_FREQ_HZ/F1_HZ, DIV2 = F1_HZ/F2_HZ.
//   Both divisions are exact integers and DIV1>=2, DIV2>=2; any violation is an elaboration error.
//
// PORTS
//   CLK        in   1  system clock, 50 MHz
//   RESET_N    in   1  synchronous reset, active low
//   EN         in   1  count enable; 0 freezes all counters
//   SYNC_CLR   in   1  synchronous phase restart of both dividers
//   CLK_1MHz   out  1  ~50% duty square wave, period DIV1 CLK cycles
//   CLK_1Hz    out  1  ~50% duty square wave, period DIV1*DIV2 CLK cycles
//   TICK_1MHz  out  1  1-cycle strobe, once per CLK_1MHz period
//   TICK_1Hz   out  1  1-cycle strobe, once per CLK_1Hz period
//
// BEHAVIOUR
//   Internal counters
//     - cnt1: width $clog2(DIV1), range 0..DIV1-1.
//     - cnt2: width $clog2(DIV2), range 0..DIV2-1.
//   Priority: RESET_N=0 > SYNC_CLR=1 > EN. All actions happen on posedge CLK.
//   Reset (RESET_N=0)
//     - cnt1=0, cnt2=0.
//     - All four outputs = 0 on the following cycle.
//   SYNC_CLR=1: identical effect to reset, regardless of EN.
//   EN=1, normal counting
//     - cnt1 <= (cnt1==DIV1-1) ? 0 : cnt1+1.
//     - cnt2 advances only in a cycle where cnt1==DIV1-1: cnt2 <= (cnt2==DIV2-1) ? 0 : cnt2+1.
//   EN=0
//     - Counters hold; CLK_1MHz and CLK_1Hz hold their level.
//     - TICK_1MHz and TICK_1Hz are 0.
//   Output decode
//     - Output registers are loaded from next-count values, so outputs track the counter with
//       zero extra lag.
//     - CLK_1MHz = 1 iff cnt1 >= DIV1/2 (integer division).
//     - CLK_1Hz  = 1 iff cnt2 >= DIV2/2.
//     - TICK_1MHz = 1 iff EN && cnt1==DIV1-1, i.e. the last cycle of each 1 MHz period.
//     - TICK_1Hz  = 1 iff EN && cnt1==DIV1-1 && cnt2==DIV2-1.
//   Phase and duty
//     - After reset, CLK_1MHz is low for floor(DIV1/2) cycles, then high for DIV1-floor(DIV1/2).
//     - Odd DIV gives the extra cycle to the high phase. CLK_1Hz follows the same rule in units
//       of DIV1 cycles.
//     - Wrap: cnt1 DIV1-1 -> 0 coincides with the CLK_1MHz falling edge.
//     - TICK_1Hz always coincides with a TICK_1MHz.
//   Mid-operation reset / SYNC_CLR
//     - Restarts both phases immediately.
//     - No partial tick is emitted in that cycle.
//
// TESTING
//   1) Defaults, RESET_N released at t0 with EN=1 -> CLK_1MHz 25 cycles low / 25 high, repeating;
//      TICK_1MHz on cycles 49, 99, 149...
//   2) CLK_FREQ_HZ=50, F1_HZ=10, F2_HZ=2 (DIV1=5, DIV2=5)
//      -> CLK_1MHz pattern 0,0,1,1,1; CLK_1Hz low 10 / high 15 cycles;
//         TICK_1Hz on cycle 24, 49...
//   3) Same params, EN=0 for 7 cycles at cnt1=3
//      -> outputs frozen, no ticks; sequence resumes at cnt1=4, overall period stretched by
//         exactly 7.
//   4) SYNC_CLR pulsed with cnt1=DIV1-1 and EN=1 -> no tick that cycle; all outputs 0 next cycle;
//      first TICK_1MHz DIV1 cycles later.
//   5) RESET_N=0 mid-high-phase of CLK_1Hz -> next cycle all outputs 0; counters restart from 0.
//   6) Param check: F1_HZ=3_000_000 with default CLK (non-integer DIV1) -> elaboration fails.

Source files
------------

// File: rtl/clk_prescaler.sv
// ----------------------------------------------------------------------------
// clk_prescaler
//   Derives two slow square-wave timing signals and their single-cycle tick
//   strobes from the system clock. Every output is a plain data signal that is
//   registered in the CLK domain; none of them is ever used as a clock.
//
//   Parameters
//     CLK_FREQ_HZ  frequency of CLK
//     F1_HZ        frequency of CLK_1MHz / TICK_1MHz  (DIV1 = CLK_FREQ_HZ/F1_HZ)
//     F2_HZ        frequency of CLK_1Hz  / TICK_1Hz   (DIV2 = F1_HZ/F2_HZ)
//
//   Ports
//     CLK        in   system clock
//     RESET_N    in   synchronous reset, active low
//     EN         in   count enable; 0 freezes both dividers
//     SYNC_CLR   in   synchronous phase restart of both dividers
//     CLK_1MHz   out  ~50% square wave, period DIV1 CLK cycles
//     CLK_1Hz    out  ~50% square wave, period DIV1*DIV2 CLK cycles
//     TICK_1MHz  out  1-cycle strobe in the last cycle of each CLK_1MHz period
//     TICK_1Hz   out  1-cycle strobe in the last cycle of each CLK_1Hz period
// ----------------------------------------------------------------------------
module clk_prescaler #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned F1_HZ       = 1_000_000,
   parameter int unsigned F2_HZ       = 1
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic EN,
   input  logic SYNC_CLR,
   output logic CLK_1MHz,
   output logic CLK_1Hz,
   output logic TICK_1MHz,
   output logic TICK_1Hz
);

   localparam int unsigned DIV1 = (F1_HZ == 0) ? 0 : CLK_FREQ_HZ / F1_HZ;
   localparam int unsigned DIV2 = (F2_HZ == 0) ? 0 : F1_HZ / F2_HZ;

   // Widths are clamped so an illegal parameter set still reaches the
   // elaboration error below instead of tripping over a zero-width vector.
   localparam int unsigned W1 = (DIV1 < 2) ? 1 : $clog2(DIV1);
   localparam int unsigned W2 = (DIV2 < 2) ? 1 : $clog2(DIV2);

   localparam logic [W1-1:0] LAST1 = W1'(DIV1 - 1);
   localparam logic [W1-1:0] HALF1 = W1'(DIV1 / 2);
   localparam logic [W2-1:0] LAST2 = W2'(DIV2 - 1);
   localparam logic [W2-1:0] HALF2 = W2'(DIV2 / 2);

   if (F1_HZ == 0 || (CLK_FREQ_HZ % F1_HZ) != 0 || DIV1 < 2) begin : g_bad_div1
      $error("clk_prescaler: CLK_FREQ_HZ/F1_HZ must be an exact integer >= 2");
   end

   if (F2_HZ == 0 || (F1_HZ % F2_HZ) != 0 || DIV2 < 2) begin : g_bad_div2
      $error("clk_prescaler: F1_HZ/F2_HZ must be an exact integer >= 2");
   end

   logic [W1-1:0] cnt1;
   logic [W2-1:0] cnt2;
   logic [W1-1:0] cnt1_nxt;
   logic [W2-1:0] cnt2_nxt;
   logic          wrap1;

   // Next-count logic. The output registers below decode these next values so
   // the outputs line up with the counter state without an extra cycle of lag.
   always_comb begin
      cnt1_nxt = cnt1;
      cnt2_nxt = cnt2;
      wrap1    = (cnt1 == LAST1);
      if (EN) begin
         cnt1_nxt = wrap1 ? '0 : cnt1 + W1'(1);
         if (wrap1) begin
            cnt2_nxt = (cnt2 == LAST2) ? '0 : cnt2 + W2'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N || SYNC_CLR) begin
         cnt1      <= '0;
         cnt2      <= '0;
         CLK_1MHz  <= 1'b0;
         CLK_1Hz   <= 1'b0;
         TICK_1MHz <= 1'b0;
         TICK_1Hz  <= 1'b0;
      end else begin
         cnt1      <= cnt1_nxt;
         cnt2      <= cnt2_nxt;
         CLK_1MHz  <= (cnt1_nxt >= HALF1);
         CLK_1Hz   <= (cnt2_nxt >= HALF2);
         // Gating by EN keeps a frozen divider from repeating its tick while it
         // sits on the last count.
         TICK_1MHz <= EN && (cnt1_nxt == LAST1);
         TICK_1Hz  <= EN && (cnt1_nxt == LAST1) && (cnt2_nxt == LAST2);
      end
   end

endmodule

// File: tb/tb_clk_prescaler.sv
// ----------------------------------------------------------------------------
// tb_clk_prescaler
//   Self-checking bench for clk_prescaler. Two instances share the controls:
//   u_def with default parameters (DIV1=50) and u_small with DIV1=5, DIV2=5.
//   A behavioural model of the small instance pushes its expected outputs
//   {CLK_1MHz, CLK_1Hz, TICK_1MHz, TICK_1Hz} into a queue each time a cycle
//   is driven; scenario tasks pop and compare after the edge, and also check
//   absolute timing facts (tick cycles, phase lengths) as plain constants.
// ----------------------------------------------------------------------------
module tb_clk_prescaler;

   localparam int S_DIV1 = 5;
   localparam int S_DIV2 = 5;

   logic clk;
   logic reset_n;
   logic en;
   logic sync_clr;

   logic d_clk1, d_clk2, d_t1, d_t2;
   logic s_clk1, s_clk2, s_t1, s_t2;
   logic [3:0] def_out;
   logic [3:0] small_out;

   assign def_out   = {d_clk1, d_clk2, d_t1, d_t2};
   assign small_out = {s_clk1, s_clk2, s_t1, s_t2};

   clk_prescaler u_def (
      .CLK       (clk),
      .RESET_N   (reset_n),
      .EN        (en),
      .SYNC_CLR  (sync_clr),
      .CLK_1MHz  (d_clk1),
      .CLK_1Hz   (d_clk2),
      .TICK_1MHz (d_t1),
      .TICK_1Hz  (d_t2)
   );

   clk_prescaler #(
      .CLK_FREQ_HZ (50),
      .F1_HZ       (10),
      .F2_HZ       (2)
   ) u_small (
      .CLK       (clk),
      .RESET_N   (reset_n),
      .EN        (en),
      .SYNC_CLR  (sync_clr),
      .CLK_1MHz  (s_clk1),
      .CLK_1Hz   (s_clk2),
      .TICK_1MHz (s_t1),
      .TICK_1Hz  (s_t2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int compared   = 0;
   int mismatched = 0;

   int m_c1 = 0;
   int m_c2 = 0;

   logic [3:0] q_exp[$];
   logic [3:0] q_def[$];

   // Applies one cycle of inputs, advances the small-instance model and
   // queues its expected outputs, then waits until just after the edge.
   task automatic drive_cycle(input logic rstn, input logic en_i, input logic clr);
      logic [3:0] e;
      reset_n  = rstn;
      en       = en_i;
      sync_clr = clr;
      e = 4'b0000;
      if (!rstn || clr) begin
         m_c1 = 0;
         m_c2 = 0;
      end else begin
         if (en_i) begin
            if (m_c1 == S_DIV1 - 1) begin
               m_c1 = 0;
               m_c2 = (m_c2 == S_DIV2 - 1) ? 0 : m_c2 + 1;
            end else begin
               m_c1 = m_c1 + 1;
            end
            e[1] = (m_c1 == S_DIV1 - 1);
            e[0] = (m_c1 == S_DIV1 - 1) && (m_c2 == S_DIV2 - 1);
         end
         e[3] = (m_c1 >= S_DIV1 / 2);
         e[2] = (m_c2 >= S_DIV2 / 2);
      end
      q_exp.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] expv;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b0);
         expv = q_exp.pop_front();
         compared++;
         if (small_out !== expv) begin
            mismatched++;
            $display("FAIL reset_small: got %b expected %b", small_out, expv);
         end
         compared++;
         if (def_out !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_default: got %b expected %b", def_out, 4'b0000);
         end
      end
   endtask

   // Default parameters: CLK_1MHz 25 low / 25 high, TICK_1MHz on cycles 49, 99, 149.
   task automatic test_default();
      logic [3:0] expv;
      int ticks;
      ticks = 0;
      drive_cycle(1'b0, 1'b1, 1'b0);
      void'(q_exp.pop_front());
      for (int n = 1; n <= 150; n++) begin
         q_def.push_back({((n % 50) >= 25), 1'b0, ((n % 50) == 49), 1'b0});
         drive_cycle(1'b1, 1'b1, 1'b0);
         expv = q_def.pop_front();
         compared++;
         if (def_out !== expv) begin
            mismatched++;
            $display("FAIL default_cycle%0d: got %b expected %b", n, def_out, expv);
         end
         if (d_t1 === 1'b1) ticks++;
         expv = q_exp.pop_front();
         compared++;
         if (small_out !== expv) begin
            mismatched++;
            $display("FAIL default_small_cycle%0d: got %b expected %b", n, small_out, expv);
         end
      end
      compared++;
      if (ticks !== 3) begin
         mismatched++;
         $display("FAIL default_tick_count: got %0d expected %0d", ticks, 3);
      end
   endtask

   // DIV1=5, DIV2=5: CLK_1MHz 0,0,1,1,1; CLK_1Hz low 10 cycles; TICK_1Hz at 24, 49.
   task automatic test_small_pattern();
      logic [3:0] expv;
      logic [4:0] pat;
      int low2;
      int t2_first;
      int t2_second;
      pat       = '0;
      low2      = 0;
      t2_first  = -1;
      t2_second = -1;
      drive_cycle(1'b0, 1'b1, 1'b0);
      void'(q_exp.pop_front());
      pat  = {pat[3:0], s_clk1};
      low2 = (s_clk2 === 1'b0) ? 1 : 0;
      for (int n = 1; n <= 50; n++) begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         expv = q_exp.pop_front();
         compared++;
         if (small_out !== expv) begin
            mismatched++;
            $display("FAIL pattern_cycle%0d: got %b expected %b", n, small_out, expv);
         end
         if (n < 5) pat = {pat[3:0], s_clk1};
         if (n < 25 && s_clk2 === 1'b0) low2++;
         if (s_t2 === 1'b1) begin
            if (t2_first < 0) t2_first = n;
            else if (t2_second < 0) t2_second = n;
         end
      end
      compared++;
      if (pat !== 5'b00111) begin
         mismatched++;
         $display("FAIL pattern_clk1: got %b expected %b", pat, 5'b00111);
      end
      compared++;
      if (low2 !== 10) begin
         mismatched++;
         $display("FAIL pattern_clk2_low: got %0d expected %0d", low2, 10);
      end
      compared++;
      if (t2_first !== 24 || t2_second !== 49) begin
         mismatched++;
         $display("FAIL pattern_tick1hz: got %0d,%0d expected 24,49", t2_first, t2_second);
      end
   endtask

   // EN low for 7 cycles while cnt1=3: ticks move from cycles 4, 9 to 11, 16.
   task automatic test_enable_freeze();
      logic [3:0] expv;
      int t1_first;
      int t1_second;
      logic en_n;
      t1_first  = -1;
      t1_second = -1;
      drive_cycle(1'b0, 1'b1, 1'b0);
      void'(q_exp.pop_front());
      for (int n = 1; n <= 20; n++) begin
         en_n = !(n >= 4 && n <= 10);
         drive_cycle(1'b1, en_n, 1'b0);
         expv = q_exp.pop_front();
         compared++;
         if (small_out !== expv) begin
            mismatched++;
            $display("FAIL freeze_cycle%0d: got %b expected %b", n, small_out, expv);
         end
         if (s_t1 === 1'b1) begin
            if (t1_first < 0) t1_first = n;
            else if (t1_second < 0) t1_second = n;
         end
      end
      compared++;
      if (t1_first !== 11 || t1_second !== 16) begin
         mismatched++;
         $display("FAIL freeze_tick_cycles: got %0d,%0d expected 11,16", t1_first, t1_second);
      end
   endtask

   // SYNC_CLR on the last count: zeros next cycle, then the first tick DIV1 edges later.
   task automatic test_sync_clr();
      logic [3:0] expv;
      int first_tick;
      first_tick = -1;
      drive_cycle(1'b0, 1'b1, 1'b0);
      void'(q_exp.pop_front());
      for (int n = 1; n <= 4; n++) begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         void'(q_exp.pop_front());
      end
      compared++;
      if (s_t1 !== 1'b1) begin
         mismatched++;
         $display("FAIL sync_clr_setup_tick: got %b expected %b", s_t1, 1'b1);
      end
      drive_cycle(1'b1, 1'b1, 1'b1);
      expv = q_exp.pop_front();
      compared++;
      if (small_out !== 4'b0000 || small_out !== expv) begin
         mismatched++;
         $display("FAIL sync_clr_zero: got %b expected %b", small_out, 4'b0000);
      end
      for (int k = 2; k <= 8; k++) begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         expv = q_exp.pop_front();
         compared++;
         if (small_out !== expv) begin
            mismatched++;
            $display("FAIL sync_clr_edge%0d: got %b expected %b", k, small_out, expv);
         end
         if (s_t1 === 1'b1 && first_tick < 0) first_tick = k;
      end
      compared++;
      if (first_tick !== S_DIV1) begin
         mismatched++;
         $display("FAIL sync_clr_first_tick: got %0d expected %0d", first_tick, S_DIV1);
      end
      // Clear with EN low must still restart the phase.
      drive_cycle(1'b1, 1'b0, 1'b1);
      expv = q_exp.pop_front();
      compared++;
      if (small_out !== 4'b0000 || small_out !== expv) begin
         mismatched++;
         $display("FAIL sync_clr_en0: got %b expected %b", small_out, 4'b0000);
      end
   endtask

   // Reset during the high phase of CLK_1Hz restarts both dividers.
   task automatic test_mid_reset();
      logic [3:0] expv;
      int low2;
      drive_cycle(1'b0, 1'b1, 1'b0);
      void'(q_exp.pop_front());
      for (int n = 1; n <= 12; n++) begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         void'(q_exp.pop_front());
      end
      compared++;
      if (s_clk2 !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_reset_setup: got %b expected %b", s_clk2, 1'b1);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
      expv = q_exp.pop_front();
      compared++;
      if (small_out !== 4'b0000 || small_out !== expv) begin
         mismatched++;
         $display("FAIL mid_reset_zero: got %b expected %b", small_out, 4'b0000);
      end
      low2 = 1;
      for (int n = 1; n <= 30; n++) begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         expv = q_exp.pop_front();
         compared++;
         if (small_out !== expv) begin
            mismatched++;
            $display("FAIL mid_reset_cycle%0d: got %b expected %b", n, small_out, expv);
         end
         if (n < 25 && s_clk2 === 1'b0) low2++;
      end
      compared++;
      if (low2 !== 10) begin
         mismatched++;
         $display("FAIL mid_reset_clk2_low: got %0d expected %0d", low2, 10);
      end
   endtask

   // Random mix of enable gaps, clears and resets against the model.
   task automatic test_back_to_back();
      logic [3:0] expv;
      logic rstn, en_r, clr;
      for (int n = 0; n < 400; n++) begin
         rstn = ($urandom_range(0, 59) != 0);
         clr  = ($urandom_range(0, 39) == 0);
         en_r = ($urandom_range(0, 3) != 0);
         drive_cycle(rstn, en_r, clr);
         expv = q_exp.pop_front();
         compared++;
         if (small_out !== expv) begin
            mismatched++;
            $display("FAIL random_cycle%0d: got %b expected %b", n, small_out, expv);
         end
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      en       = 1'b0;
      sync_clr = 1'b0;
      test_reset();
      test_default();
      test_small_pattern();
      test_enable_freeze();
      test_sync_clr();
      test_mid_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
